// File: rtl/filter_weight_sequencer.sv
// Walks filters 0..n-1 through the weight ROM and holds each one for the conv engine until conv_done.
// Optional busy-cycle counter under FILTER_SEQ_PERF_EN; the ROM read latency (MEM_LAT) sets the fetch-to-present gap.
module filter_weight_sequencer #(
  parameter int addressWidthFilter = 6,
  parameter int WORDS_PER_FILTER   = 10,
  parameter int MAX_FILTERS        = 4,
  parameter int filtIdxWidth       = 2,
  parameter int MEM_LAT            = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [filtIdxWidth:0]         i_cfg_num_filters,
  input  logic                          i_conv_done,
  output logic                          o_mem_en,
  output logic [addressWidthFilter-1:0] o_mem_addr,
  output logic                          o_filt_valid,
  output logic [filtIdxWidth-1:0]       o_filt_idx,
  output logic                          o_busy,
  output logic                          o_done
`ifdef FILTER_SEQ_PERF_EN
  ,
  output logic [31:0]                   o_busy_cycles
`endif
);

  localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [filtIdxWidth:0]         C_MAX_N  = (filtIdxWidth+1)'(MAX_FILTERS);
  localparam logic [addressWidthFilter-1:0] C_STRIDE = addressWidthFilter'(WORDS_PER_FILTER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t                        r_state;
  state_t                        w_next_state;
  logic [filtIdxWidth:0]         r_n;
  logic [filtIdxWidth-1:0]       r_idx;
  logic [addressWidthFilter-1:0] r_addr;
  logic [WAIT_W-1:0]             r_wait_cnt;

  logic                          w_accept;
  logic                          w_advance;
  logic [filtIdxWidth:0]         w_n_clamped;
  logic [filtIdxWidth:0]         w_last_idx;
  logic                          w_is_last;

  assign w_n_clamped = (i_cfg_num_filters > C_MAX_N) ? C_MAX_N : i_cfg_num_filters;
  assign w_last_idx  = r_n - (filtIdxWidth+1)'(1);
  assign w_is_last   = ({1'b0, r_idx} == w_last_idx);

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_next_state = (w_n_clamped == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        w_next_state = (MEM_LAT == 1) ? S_PRESENT : S_WAIT;
      end
      S_WAIT: begin
        // Counter holds the remaining wait cycles including this one.
        if (r_wait_cnt <= WAIT_W'(1)) begin
          w_next_state = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (i_conv_done) begin
          if (w_is_last) begin
            w_next_state = S_DONE;
          end else begin
            w_advance    = 1'b1;
            w_next_state = S_FETCH;
          end
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_n    <= w_n_clamped;
        r_idx  <= '0;
        r_addr <= '0;
      end
      // Base address accumulates by the stride instead of idx*WORDS_PER_FILTER.
      if (w_advance) begin
        r_idx  <= r_idx + filtIdxWidth'(1);
        r_addr <= r_addr + C_STRIDE;
      end
      if (r_state == S_FETCH) begin
        r_wait_cnt <= WAIT_W'(MEM_LAT - 1);
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
      end
    end
  end

  assign o_mem_en     = (r_state == S_FETCH);
  assign o_filt_valid = (r_state == S_PRESENT);
  assign o_busy       = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_PRESENT);
  assign o_done       = (r_state == S_DONE);
  assign o_mem_addr   = r_addr;
  assign o_filt_idx   = r_idx;

`ifdef FILTER_SEQ_PERF_EN
  logic [31:0] r_busy_cycles;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy_cycles <= '0;
    end else if (w_accept) begin
      r_busy_cycles <= '0;
    end else if (o_busy && (r_busy_cycles != 32'hFFFF_FFFF)) begin
      r_busy_cycles <= r_busy_cycles + 32'd1;
    end
  end

  assign o_busy_cycles = r_busy_cycles;
`endif

endmodule
